// File: rtl/psram_ctrl_if.sv
// rtl/psram_ctrl_if.sv - host request/response bus between a requester and psram_ctrl
interface psram_ctrl_if;
   logic        i_req;
   logic        i_we;
   logic [23:0] i_addr;
   logic [31:0] i_data;
   logic [31:0] o_data;
   logic        o_data_ready;
   logic        o_busy;

   modport master (output i_req, i_we, i_addr, i_data,
                   input  o_data, o_data_ready, o_busy);
   modport slave  (input  i_req, i_we, i_addr, i_data,
                   output o_data, o_data_ready, o_busy);
endinterface

// File: rtl/psram_ctrl.sv
// rtl/psram_ctrl.sv - x8 SDR PSRAM controller, one 32-bit word per transaction
// Define OGEGE_PSRAM_RESET_EN to send the 66h/99h reset pair after reset release.
module psram_ctrl #(
   parameter int LAT_CYC    = 5,
   parameter int CSN_HI_CLK = 4
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   psram_ctrl_if.slave bus,
   output logic        o_psram_csn,
   output logic        o_psram_sclk,
   output logic [7:0]  o_dq,
   output logic        o_dq_oe,
   input  logic [7:0]  i_dq
);
   localparam logic [7:0] CMD_RD   = 8'h20;
   localparam logic [7:0] CMD_WR   = 8'hA0;
   localparam logic [7:0] LAT_LAST = 8'(LAT_CYC - 1);
   localparam logic [7:0] HI_LAST  = 8'(CSN_HI_CLK - 1);

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, DUMMY, WDATA, RDATA,
`ifdef OGEGE_PSRAM_RESET_EN
      RECOV, INIT
`else
      RECOV
`endif
   } state_t;

   state_t      state;
   logic        go;
   logic        ph;
   logic        we_q;
   logic [23:0] addr_q;
   logic [31:0] wdata_q;
   logic [23:0] rbuf;
   logic [7:0]  cnt;
`ifdef OGEGE_PSRAM_RESET_EN
   localparam logic [7:0] CMD_RSTEN = 8'h66;
   localparam logic [7:0] CMD_RST   = 8'h99;
   logic [1:0]  init_sub;
`endif

   // ph=0 is phase A (sclk low, dq just updated), ph=1 is phase B (sclk high)
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         o_psram_csn      <= 1'b1;
         o_psram_sclk     <= 1'b0;
         o_dq             <= 8'h00;
         o_dq_oe          <= 1'b0;
         bus.o_data       <= 32'h0;
         bus.o_data_ready <= 1'b0;
         go               <= 1'b0;
         ph               <= 1'b0;
         we_q             <= 1'b0;
         addr_q           <= 24'h0;
         wdata_q          <= 32'h0;
         rbuf             <= 24'h0;
         cnt              <= 8'h0;
`ifdef OGEGE_PSRAM_RESET_EN
         state            <= INIT;
         bus.o_busy       <= 1'b1;
         init_sub         <= 2'd0;
`else
         state            <= IDLE;
         bus.o_busy       <= 1'b0;
`endif
      end else begin
         bus.o_data_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (go) begin
                  go           <= 1'b0;
                  o_psram_csn  <= 1'b0;
                  o_psram_sclk <= 1'b0;
                  o_dq         <= we_q ? CMD_WR : CMD_RD;
                  o_dq_oe      <= 1'b1;
                  ph           <= 1'b0;
                  state        <= CMD;
               end else if (bus.i_req && !bus.o_busy) begin
                  we_q       <= bus.i_we;
                  addr_q     <= bus.i_addr;
                  wdata_q    <= bus.i_data;
                  go         <= 1'b1;
                  bus.o_busy <= 1'b1;
               end
            end
            CMD, ADDR, DUMMY, WDATA, RDATA: begin
               if (!ph) begin
                  o_psram_sclk <= 1'b1;
                  ph           <= 1'b1;
               end else begin
                  o_psram_sclk <= 1'b0;
                  ph           <= 1'b0;
                  case (state)
                     CMD: begin
                        o_dq   <= addr_q[23:16];
                        addr_q <= {addr_q[15:0], 8'h00};
                        cnt    <= 8'd0;
                        state  <= ADDR;
                     end
                     ADDR: begin
                        if (cnt == 8'd2) begin
                           cnt <= 8'd0;
                           if (we_q) begin
                              o_dq    <= wdata_q[7:0];
                              wdata_q <= {8'h00, wdata_q[31:8]};
                              state   <= WDATA;
                           end else begin
                              o_dq    <= 8'h00;
                              o_dq_oe <= 1'b0;
                              state   <= (LAT_CYC == 0) ? RDATA : DUMMY;
                           end
                        end else begin
                           o_dq   <= addr_q[23:16];
                           addr_q <= {addr_q[15:0], 8'h00};
                           cnt    <= cnt + 8'd1;
                        end
                     end
                     DUMMY: begin
                        if (cnt == LAT_LAST) begin
                           cnt   <= 8'd0;
                           state <= RDATA;
                        end else begin
                           cnt <= cnt + 8'd1;
                        end
                     end
                     WDATA: begin
                        if (cnt == 8'd3) begin
                           o_psram_csn      <= 1'b1;
                           o_dq             <= 8'h00;
                           o_dq_oe          <= 1'b0;
                           bus.o_data_ready <= 1'b1;
                           cnt              <= 8'd0;
                           state            <= RECOV;
                        end else begin
                           o_dq    <= wdata_q[7:0];
                           wdata_q <= {8'h00, wdata_q[31:8]};
                           cnt     <= cnt + 8'd1;
                        end
                     end
                     RDATA: begin
                        // first byte received ends up in o_data[7:0]
                        rbuf <= {i_dq, rbuf[23:8]};
                        if (cnt == 8'd3) begin
                           bus.o_data       <= {i_dq, rbuf};
                           o_psram_csn      <= 1'b1;
                           bus.o_data_ready <= 1'b1;
                           cnt              <= 8'd0;
                           state            <= RECOV;
                        end else begin
                           cnt <= cnt + 8'd1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            RECOV: begin
               if (cnt == HI_LAST) begin
                  bus.o_busy <= 1'b0;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
`ifdef OGEGE_PSRAM_RESET_EN
            INIT: begin
               case (init_sub)
                  2'd0: begin
                     o_psram_csn  <= 1'b0;
                     o_psram_sclk <= 1'b0;
                     o_dq         <= CMD_RSTEN;
                     o_dq_oe      <= 1'b1;
                     ph           <= 1'b0;
                     init_sub     <= 2'd1;
                  end
                  2'd2: begin
                     if (cnt == HI_LAST) begin
                        o_psram_csn <= 1'b0;
                        o_dq        <= CMD_RST;
                        o_dq_oe     <= 1'b1;
                        ph          <= 1'b0;
                        init_sub    <= 2'd3;
                     end else begin
                        cnt <= cnt + 8'd1;
                     end
                  end
                  default: begin
                     if (!ph) begin
                        o_psram_sclk <= 1'b1;
                        ph           <= 1'b1;
                     end else begin
                        o_psram_sclk <= 1'b0;
                        ph           <= 1'b0;
                        o_psram_csn  <= 1'b1;
                        o_dq         <= 8'h00;
                        o_dq_oe      <= 1'b0;
                        cnt          <= 8'd0;
                        if (init_sub == 2'd1) init_sub <= 2'd2;
                        else                  state    <= RECOV;
                     end
                  end
               endcase
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/psram_ctrl.md
PSRAM_CTRL -- requirements
Module: psram_ctrl

Interface
REQ-001 SHALL have parameter LAT_CYC, default 5: number of dummy SCLK cycles between address and read data.
REQ-002 SHALL have parameter CSN_HI_CLK, default 4: minimum clk_i cycles o_psram_csn stays high between transactions.
REQ-003 SHALL have port clk_i, input, 1: single clock, 100 MHz.
REQ-004 SHALL have port rstn_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_req, input, 1: request; sampled only while o_busy=0.
REQ-006 SHALL have port i_we, input, 1: 1=write, 0=read; qualified by i_req.
REQ-007 SHALL have port i_addr, input, 24: byte address.
REQ-008 SHALL have port i_data, input, 32: write word.
REQ-009 SHALL have port o_data, output, 32: read word; valid with o_data_ready.
REQ-010 SHALL have port o_data_ready, output, 1: one-cycle completion pulse for reads and writes.
REQ-011 SHALL have port o_busy, output, 1: transaction in progress or CS recovery.
REQ-012 SHALL have port o_psram_csn, output, 1: chip select, active-low.
REQ-013 SHALL have port o_psram_sclk, output, 1: PSRAM serial clock.
REQ-014 SHALL have port o_dq, output, 8: data bus drive value.
REQ-015 SHALL have port o_dq_oe, output, 1: 1=drive io_psram_data[7:0]; the tristate buffer sits in the top level.
REQ-016 SHALL have port i_dq, input, 8: data bus sampled value.

Function
REQ-017 SHALL implement states IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, RECOV, plus INIT when the macro in REQ-029 is defined.
REQ-018 SHALL, in IDLE with i_req=1, latch i_we/i_addr/i_data; on the next clk_i, drive csn low and enter CMD.
REQ-019 SHALL run SDR at one SCLK per 2 clk_i while csn is low:
- sclk low in phase A, high in phase B.
- o_dq changes only at phase A entry.
- i_dq is sampled on the clk_i edge ending phase B.
REQ-020 SHALL send the command byte: 8'h20 for read, 8'hA0 for write.
REQ-021 SHALL send the address as 3 bytes, MSB first.
REQ-022 SHALL, for a read:
- hold o_dq_oe=0 through LAT_CYC DUMMY SCLKs and 4 RDATA SCLKs;
- assemble bytes little-endian (first byte received -> o_data[7:0]).
REQ-023 SHALL, for a write, send i_data as 4 WDATA bytes, little-endian, with o_dq_oe=1.
REQ-024 SHALL, after the last data SCLK:
- raise csn and drop sclk to 0;
- pulse o_data_ready for 1 cycle;
- hold o_busy=1 in RECOV for CSN_HI_CLK cycles, then return to IDLE.
REQ-025 SHALL keep sclk=0 and o_dq_oe=0 whenever csn=1.
REQ-026 SHALL produce these fixed transaction lengths, from request-sample edge to o_data_ready pulse:
- read: 1 + 2*(8+LAT_CYC) clk_i = 27 at default;
- write: 17 clk_i.
REQ-027 SHALL assert o_busy from the cycle after i_req is accepted; requests while o_busy=1 are ignored, with no queuing.
REQ-028 SHALL hold o_data unchanged from a read's o_data_ready until the next read completes; writes do not alter o_data.

Configuration
REQ-029 SHALL, with OGEGE_PSRAM_RESET_EN defined, after reset release first run INIT:
- send single-byte command 8'h66, then CSN_HI_CLK cycles csn high, then 8'h99, then RECOV;
- hold o_busy=1 throughout INIT;
- emit no o_data_ready pulse for INIT.
Without the macro, the controller SHALL enter IDLE directly after reset.

Reset
REQ-030 SHALL, while rstn_i=0, immediately and asynchronously force:
- csn=1, sclk=0, o_dq=0, o_dq_oe=0;
- o_data=0, o_data_ready=0;
- state IDLE, or INIT when the macro is defined;
- o_busy=0, or 1 when the macro is defined.
REQ-031 SHALL, on reset assertion mid-transaction, abort with no o_data_ready pulse; the first post-reset transaction SHALL be complete and correct.

Verification
REQ-032 SHALL verify this scenario: read addr 24'h012345 against a PSRAM model returning bytes 11,22,33,44 -> bus shows 20,01,23,45, then 5 dummy SCLKs; o_data=32'h44332211 pulses at cycle 27.
REQ-033 SHALL verify this scenario: write addr 24'hFFFFFF, data 32'hDEADBEEF -> bytes A0,FF,FF,FF,EF,BE,AD,DE with oe=1; o_data_ready at cycle 17; o_data unchanged.
REQ-034 SHALL verify this scenario: back-to-back i_req held high -> second csn fall no sooner than CSN_HI_CLK=4 cycles after the first csn rise; i_req pulses during busy are dropped.
REQ-035 SHALL verify this scenario: rstn_i low during RDATA byte 2 -> csn=1, sclk=0, oe=0 the same cycle; no ready pulse; a subsequent read returns correct data.
REQ-036 SHALL verify this scenario: with OGEGE_PSRAM_RESET_EN defined -> 66, gap of 4 cycles, then 99 after reset; o_busy=1 until RECOV ends; a request during INIT is ignored.
REQ-037 SHALL verify this scenario: protocol checker over all tests -> sclk never toggles while csn=1; o_dq stable across every sclk rising edge.
